// File: rtl/eight_bit_divider.sv
// -----------------------------------------------------------------------------
// eight_bit_divider
//
// Multi-cycle unsigned restoring divider. An accepted start loads the operands
// and runs one restoring step per clock for WIDTH clocks, then pulses done for
// one cycle with the quotient and remainder. A zero divisor skips the
// iteration and reports div_by_zero on the next cycle, with quotient all ones
// and remainder equal to the dividend.
//
// Ports
//   clk          : clock, all state changes on the rising edge
//   rst_n        : asynchronous active-low reset
//   start        : divide request, sampled only while idle
//   A            : unsigned dividend, sampled with start
//   B            : unsigned divisor, sampled with start
//   quotient     : registered quotient, held until the next accepted start
//   remainder    : registered remainder, held until the next accepted start
//   busy         : high while the iteration is running
//   done         : one-cycle pulse, results valid
//   div_by_zero  : high with done when the sampled divisor was zero
// -----------------------------------------------------------------------------
module eight_bit_divider #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    // work_q shifts the dividend out of its MSB while quotient bits enter
    // at its LSB, so after WIDTH steps it holds the complete quotient.
    logic [WIDTH-1:0]   work_q, work_d;
    logic [WIDTH-1:0]   divisor_q, divisor_d;
    logic [WIDTH-1:0]   prem_q, prem_d;
    logic [WIDTH-1:0]   quotient_q, quotient_d;
    logic [WIDTH-1:0]   remainder_q, remainder_d;
    logic               dbz_q, dbz_d;

    // One restoring step. The shifted partial remainder can reach
    // 2^(WIDTH+1)-1, so the trial subtraction needs WIDTH+1 bits; its MSB
    // is the borrow that says the divisor did not fit.
    logic [WIDTH:0]     shifted;
    logic [WIDTH:0]     diff;
    logic               fits;
    logic [WIDTH-1:0]   step_rem;
    logic [WIDTH-1:0]   step_work;

    always_comb begin
        shifted   = {prem_q, work_q[WIDTH-1]};
        diff      = shifted - {1'b0, divisor_q};
        fits      = ~diff[WIDTH];
        // On restore the shifted value is below the divisor, so its top bit
        // is zero and dropping it loses nothing.
        step_rem  = fits ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
        step_work = (work_q << 1) | WIDTH'(fits);
    end

    // Next-state and datapath control.
    always_comb begin
        // NOTE: every signal gets a default before the case so that no path
        // leaves one unassigned, which would otherwise infer a latch.
        state_d     = state_q;
        cnt_d       = cnt_q;
        work_d      = work_q;
        divisor_d   = divisor_q;
        prem_d      = prem_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (B == '0) begin
                        quotient_d  = '1;
                        remainder_d = A;
                        dbz_d       = 1'b1;
                        state_d     = DONE;
                    end else begin
                        work_d    = A;
                        divisor_d = B;
                        prem_d    = '0;
                        cnt_d     = '0;
                        dbz_d     = 1'b0;
                        state_d   = RUN;
                    end
                end
            end
            RUN: begin
                work_d = step_work;
                prem_d = step_rem;
                if (cnt_q == LAST_STEP) begin
                    // Visible results change only here, never mid-run.
                    quotient_d  = step_work;
                    remainder_d = step_rem;
                    state_d     = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            work_q      <= '0;
            divisor_q   <= '0;
            prem_q      <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // values from before this edge, independent of statement order.
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            work_q      <= work_d;
            divisor_q   <= divisor_d;
            prem_q      <= prem_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
        end
    end

    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;
    assign busy        = (state_q == RUN);
    assign done        = (state_q == DONE);

endmodule

// File: tb/tb_eight_bit_divider.sv
// -----------------------------------------------------------------------------
// tb_eight_bit_divider
//
// Self-checking bench for eight_bit_divider. A behavioural model computes the
// expected outputs each cycle from plain integer division and a countdown of
// the documented latency; a compare process checks every output against it on
// every falling edge. Directed operations additionally compare results,
// latency and busy length against hand-computed literals.
// -----------------------------------------------------------------------------
module tb_eight_bit_divider;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         busy;
    logic         done;
    logic         div_by_zero;

    int total = 0;
    int bad   = 0;

    eight_bit_divider #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .A           (a),
        .B           (b),
        .quotient    (quotient),
        .remainder   (remainder),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------------------------------------------------------------
    // Behavioural model: phase 0 idle, 1 running, 2 reporting.
    // ---------------------------------------------------------------------
    int           m_phase = 0;
    int           m_left  = 0;
    logic [W-1:0] m_q = '0, m_r = '0, m_pend_q = '0, m_pend_r = '0;
    logic         m_dbz = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase <= 0;
            m_left  <= 0;
            m_q     <= '0;
            m_r     <= '0;
            m_dbz   <= 1'b0;
        end else begin
            case (m_phase)
                0: if (start) begin
                    if (b == 0) begin
                        m_q     <= '1;
                        m_r     <= a;
                        m_dbz   <= 1'b1;
                        m_phase <= 2;
                    end else begin
                        m_pend_q <= W'(int'(a) / int'(b));
                        m_pend_r <= W'(int'(a) % int'(b));
                        m_dbz    <= 1'b0;
                        m_left   <= W;
                        m_phase  <= 1;
                    end
                end
                1: begin
                    if (m_left == 1) begin
                        m_q     <= m_pend_q;
                        m_r     <= m_pend_r;
                        m_phase <= 2;
                    end
                    m_left <= m_left - 1;
                end
                default: m_phase <= 0;
            endcase
        end
    end

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        check("cyc_busy", busy, (m_phase == 1));
        check("cyc_done", done, (m_phase == 2));
        check("cyc_dbz", div_by_zero, m_dbz);
        check("cyc_quotient", quotient, m_q);
        check("cyc_remainder", remainder, m_r);
    end

    // ---------------------------------------------------------------------
    // One operation: literal expectations for result, latency and busy length.
    // poke_at: sample index at which a start (A=1,B=1) is pulsed while busy.
    // poke_done: also pulse start during the done cycle.
    // ---------------------------------------------------------------------
    task automatic do_op(input int av, input int bv, input int exp_q, input int exp_r,
                         input int poke_at, input bit poke_done);
        int k;
        int nb;
        bit zero_div;
        zero_div = (bv == 0);
        @(negedge clk);
        start = 1'b1;
        a = W'(av);
        b = W'(bv);
        @(negedge clk);
        start = 1'b0;
        a = W'($urandom);
        b = W'($urandom);
        k = 0;
        nb = 0;
        while (!done && k < 40) begin
            if (busy) nb++;
            if (k == poke_at) begin
                start = 1'b1;
                a = 8'd1;
                b = 8'd1;
            end else begin
                start = 1'b0;
                a = W'($urandom);
                b = W'($urandom);
            end
            @(negedge clk);
            k++;
        end
        start = 1'b0;
        check("done_seen", done, 1);
        check("latency", k, zero_div ? 0 : W);
        check("busy_cycles", nb, zero_div ? 0 : W);
        check("quotient", quotient, exp_q);
        check("remainder", remainder, exp_r);
        check("div_by_zero", div_by_zero, zero_div);
        if (poke_done) begin
            start = 1'b1;
            a = 8'd7;
            b = 8'd3;
            @(negedge clk);
            start = 1'b0;
            check("start_in_done_ignored_busy", busy, 0);
            check("start_in_done_ignored_done", done, 0);
        end
    endtask

    initial begin
        // Reset state.
        #1;
        check("rst_quotient", quotient, 0);
        check("rst_remainder", remainder, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_dbz", div_by_zero, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("post_release_done", done, 0);

        // Directed scenarios with hand-computed results.
        do_op(200, 7, 28, 4, -1, 1'b0);
        do_op(255, 1, 255, 0, -1, 1'b0);
        do_op(3, 10, 0, 3, -1, 1'b0);
        do_op(5, 0, 255, 5, -1, 1'b1);
        do_op(100, 9, 11, 1, 3, 1'b1);
        do_op(0, 1, 0, 0, -1, 1'b0);
        do_op(0, 255, 0, 0, -1, 1'b0);
        do_op(255, 255, 1, 0, -1, 1'b0);
        do_op(254, 255, 0, 254, -1, 1'b0);
        do_op(128, 2, 64, 0, -1, 1'b0);
        do_op(255, 16, 15, 15, -1, 1'b0);
        do_op(0, 0, 255, 0, -1, 1'b0);
        do_op(255, 0, 255, 255, -1, 1'b0);

        // Reset in the middle of a run aborts it without a done pulse.
        @(negedge clk);
        start = 1'b1;
        a = 8'd200;
        b = 8'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrun_rst_quotient", quotient, 0);
        check("midrun_rst_remainder", remainder, 0);
        check("midrun_rst_busy", busy, 0);
        check("midrun_rst_done", done, 0);
        check("midrun_rst_dbz", div_by_zero, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        begin
            int seen;
            seen = 0;
            repeat (12) begin
                @(negedge clk);
                if (done) seen++;
            end
            check("no_done_after_abort", seen, 0);
        end
        do_op(64, 8, 8, 0, -1, 1'b0);

        // Random sample of operand pairs, expectations from integer division.
        for (int i = 0; i < 500; i++) begin
            int ra;
            int rb;
            ra = int'($urandom_range(255, 0));
            rb = int'($urandom_range(255, 0));
            if (rb == 0)
                do_op(ra, rb, 255, ra, -1, 1'b0);
            else
                do_op(ra, rb, ra / rb, ra % rb, -1, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

endmodule
